// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default width
// and the bit-counter sizing helper.
package sub_pkg;

   localparam int DEF_WIDTH = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic int cnt_bits(input int width);
      return (width < 2) ? 1 : $clog2(width + 1);
   endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: the per-bit datapath cell of the serial subtractor.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor computing A-B-bin LSB first, one bit per clock.
// Optional macro SERIAL_SUB_SATURATE_EN clamps D to zero when the result borrows.
module serial_subtractor
   import sub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             bin,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             bout
);

   localparam int CNT_W = cnt_bits(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t             state_r;
   state_t             state_next_s;
   logic               load_s;
   logic               shift_s;
   logic               finish_s;

   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   b_r;
   logic [WIDTH-1:0]   res_r;
   logic               br_r;
   logic [CNT_W-1:0]   cnt_r;

   logic               d_bit_s;
   logic               br_next_s;
   logic [WIDTH-1:0]   result_s;

   full_subtractor u_cell (
      .a    (a_r[0]),
      .b    (b_r[0]),
      .bin  (br_r),
      .d    (d_bit_s),
      .bout (br_next_s)
   );

   // State register; reset wins over any pending start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode and datapath strobes.
   always_comb begin
      state_next_s = state_r;
      load_s       = 1'b0;
      shift_s      = 1'b0;
      finish_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_next_s = SHIFT;
               load_s       = 1'b1;
            end else begin
               state_next_s = IDLE;
            end
         end
         SHIFT: begin
            shift_s = 1'b1;
            if (cnt_r == LAST_CNT) begin
               state_next_s = DONE;
            end else begin
               state_next_s = SHIFT;
            end
         end
         DONE: begin
            finish_s     = 1'b1;
            state_next_s = IDLE;
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Operand shifters, borrow chain and result accumulator (new bits enter at the MSB).
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r   <= {WIDTH{1'b0}};
         b_r   <= {WIDTH{1'b0}};
         res_r <= {WIDTH{1'b0}};
         br_r  <= 1'b0;
         cnt_r <= {CNT_W{1'b0}};
      end else if (load_s) begin
         a_r   <= A;
         b_r   <= B;
         res_r <= {WIDTH{1'b0}};
         br_r  <= bin;
         cnt_r <= {CNT_W{1'b0}};
      end else if (shift_s) begin
         a_r   <= a_r >> 1;
         b_r   <= b_r >> 1;
         res_r <= {d_bit_s, res_r[WIDTH-1:1]};
         br_r  <= br_next_s;
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         a_r   <= a_r;
         b_r   <= b_r;
         res_r <= res_r;
         br_r  <= br_r;
         cnt_r <= cnt_r;
      end
   end

   // Final value presented on D.
   always_comb begin
      result_s = res_r;
`ifdef SERIAL_SUB_SATURATE_EN
      if (br_r) begin
         result_s = {WIDTH{1'b0}};
      end else begin
         result_s = res_r;
      end
`endif
   end

   // Registered outputs; D/bout update only as DONE exits so partial words never show.
   always_ff @(posedge clk) begin
      if (rst) begin
         ready <= 1'b1;
         done  <= 1'b0;
         D     <= {WIDTH{1'b0}};
         bout  <= 1'b0;
      end else begin
         ready <= (state_next_s == IDLE);
         done  <= finish_s;
         if (finish_s) begin
            D    <= result_s;
            bout <= br_r;
         end else begin
            D    <= D;
            bout <= bout;
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor against an arithmetic model.
module tb_serial_subtractor;

   localparam int W    = 3;
   localparam int MASK = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         bin;
   logic         ready;
   logic         done;
   logic [W-1:0] D;
   logic         bout;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .bin   (bin),
      .ready (ready),
      .done  (done),
      .D     (D),
      .bout  (bout)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void model(input int a, input int b, input int bi,
                                 output logic [W-1:0] ed, output logic eb);
      eb = (a < b + bi);
      ed = W'((a - b - bi) & MASK);
`ifdef SERIAL_SUB_SATURATE_EN
      if (eb) ed = '0;
`endif
   endfunction

   // Issue one operation from a ready cycle; scrambles inputs after acceptance.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                         output logic [W-1:0] gd, output logic gb,
                         output int lat, output int dcyc);
      A = a; B = b; bin = bi; start = 1'b1;
      tick();
      start = 1'b0;
      A = W'($urandom); B = W'($urandom); bin = 1'($urandom);
      lat = 0;
      while (done !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      gd = D; gb = bout; dcyc = cyc;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; A = '0; B = '0; bin = 1'b0;
      tick(); tick();
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
      total++; if (D !== '0) begin bad++; $display("FAIL reset_D: got %0d want 0", D); end
      total++; if (bout !== 1'b0) begin bad++; $display("FAIL reset_bout: got %b want 0", bout); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_vectors();
      int va[4] = '{5, 2, 7, 0};
      int vb[4] = '{3, 5, 7, 0};
      int vi[4] = '{0, 0, 1, 0};
      logic [W-1:0] gd, ed;
      logic gb, eb;
      int lat, dc;
      for (int i = 0; i < 4; i++) begin
         model(va[i], vb[i], vi[i], ed, eb);
         run_op(W'(va[i]), W'(vb[i]), 1'(vi[i]), gd, gb, lat, dc);
         total++; if (gd !== ed) begin bad++; $display("FAIL vec%0d_D: got %0d want %0d", i, gd, ed); end
         total++; if (gb !== eb) begin bad++; $display("FAIL vec%0d_bout: got %b want %b", i, gb, eb); end
         total++; if (lat != W + 1) begin bad++; $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, W + 1); end
         total++; if (ready !== 1'b1) begin bad++; $display("FAIL vec%0d_ready_at_done: got %b want 1", i, ready); end
         tick();
         total++; if (done !== 1'b0) begin bad++; $display("FAIL vec%0d_done_width: got %b want 0", i, done); end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a, b, gd, ed;
      logic bi, gb, eb;
      int lat, dc;
      for (int i = 0; i < 24; i++) begin
         a = W'($urandom); b = W'($urandom); bi = 1'($urandom);
         model(int'(a), int'(b), int'(bi), ed, eb);
         run_op(a, b, bi, gd, gb, lat, dc);
         total++; if (gd !== ed || gb !== eb) begin
            bad++; $display("FAIL rand%0d: %0d-%0d-%0d got D=%0d bout=%b want D=%0d bout=%b", i, a, b, bi, gd, gb, ed, eb);
         end
         total++; if (lat != W + 1) begin bad++; $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, W + 1); end
         tick();
      end
   endtask

   task automatic test_ignore_start();
      int pulses = 0;
      logic [W-1:0] gd = '0;
      logic gb = 1'b1;
      A = 3'd5; B = 3'd3; bin = 1'b0; start = 1'b1;
      tick();
      A = 3'd1; B = 3'd6; bin = 1'b1; start = 1'b1;
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL busy_ready: got %b want 0", ready); end
      tick();
      start = 1'b0;
      for (int i = 0; i < 4 * W + 4; i++) begin
         if (done === 1'b1) begin
            pulses++;
            gd = D; gb = bout;
         end
         tick();
      end
      total++; if (pulses != 1) begin bad++; $display("FAIL ignore_pulses: got %0d want 1", pulses); end
      total++; if (gd !== 3'd2 || gb !== 1'b0) begin bad++; $display("FAIL ignore_result: got D=%0d bout=%b want D=2 bout=0", gd, gb); end
      total++; if (D !== 3'd2) begin bad++; $display("FAIL ignore_hold_D: got %0d want 2", D); end
   endtask

   task automatic test_midop_reset();
      int pulses = 0;
      logic [W-1:0] gd;
      logic gb;
      int lat, dc;
      A = 3'd3; B = 3'd1; bin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", ready); end
      total++; if (D !== '0 || bout !== 1'b0) begin bad++; $display("FAIL abort_outputs: got D=%0d bout=%b want D=0 bout=0", D, bout); end
      for (int i = 0; i < 3 * W; i++) begin
         if (done === 1'b1) pulses++;
         tick();
      end
      total++; if (pulses != 0) begin bad++; $display("FAIL abort_done: got %0d pulses want 0", pulses); end
      run_op(3'd6, 3'd1, 1'b0, gd, gb, lat, dc);
      total++; if (gd !== 3'd5 || gb !== 1'b0) begin bad++; $display("FAIL after_abort: got D=%0d bout=%b want D=5 bout=0", gd, gb); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] a, b, gd, ed;
      logic bi, gb, eb;
      int lat, dc, prev;
      prev = 0;
      for (int i = 0; i < 6; i++) begin
         a = W'($urandom); b = W'($urandom); bi = 1'($urandom);
         model(int'(a), int'(b), int'(bi), ed, eb);
         run_op(a, b, bi, gd, gb, lat, dc);
         total++; if (gd !== ed || gb !== eb) begin
            bad++; $display("FAIL b2b%0d: got D=%0d bout=%b want D=%0d bout=%b", i, gd, gb, ed, eb);
         end
         if (i > 0) begin
            total++; if (dc - prev != W + 2) begin bad++; $display("FAIL b2b%0d_spacing: got %0d want %0d", i, dc - prev, W + 2); end
         end
         prev = dc;
      end
      tick();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; A = '0; B = '0; bin = 1'b0;
      test_reset();
      test_vectors();
      test_random();
      test_ignore_start();
      test_midop_reset();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 3: operand/result width in bits (legal range 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset; synchronous, active-high.
REQ-004 SHALL have port start, input, 1 bit: request a subtraction; sampled only while ready=1.
REQ-005 SHALL have port A, input, WIDTH bits: minuend; captured on an accepted start.
REQ-006 SHALL have port B, input, WIDTH bits: subtrahend; captured on an accepted start.
REQ-007 SHALL have port bin, input, 1 bit: borrow-in; captured on an accepted start.
REQ-008 SHALL have port ready, output, 1 bit: high when idle and able to accept start.
REQ-009 SHALL have port done, output, 1 bit: single-cycle pulse marking D and bout valid.
REQ-010 SHALL have port D, output, WIDTH bits: difference A-B-bin, modulo 2^WIDTH.
REQ-011 SHALL have port bout, output, 1 bit: borrow-out; 1 when A < B+bin, unsigned.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-013 SHALL, in IDLE, assert ready=1 and hold D and bout at their last values.
REQ-014 SHALL, on start=1 in IDLE, load A, B and bin into internal registers, clear the bit counter and enter SHIFT on the next edge.
REQ-015 SHALL, in SHIFT, compute one bit per cycle, LSB first, using d=a^b^br and br'=(~a&b)|(~(a^b)&br).
REQ-016 SHALL shift each difference bit into the result register from the MSB side, so the word is aligned after WIDTH cycles.
REQ-017 SHALL stay in SHIFT for exactly WIDTH cycles, then enter DONE.
REQ-018 SHALL, in DONE, drive done=1 for one cycle with final D and bout, then return to IDLE.
REQ-019 SHALL give latency start-accepted-edge to done-high of WIDTH+1 cycles; ready SHALL be 0 from the edge after acceptance until DONE exits.
REQ-020 SHALL ignore start while not in IDLE; no queuing.
REQ-021 SHALL ignore A, B and bin changes after acceptance; results use only the captured values.
REQ-022 SHALL keep D and bout stable from done until the next accepted start completes; intermediate shift states SHALL NOT appear on D.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, enter IDLE and set ready=1, done=0, D=0, bout=0, and clear the counter and borrow register.
REQ-024 SHALL, when rst asserts mid-operation, abort the operation with no done pulse; rst SHALL take priority over start on the same edge.

Configuration
REQ-025 SHALL, with macro SERIAL_SUB_SATURATE_EN defined, force D=0 in DONE when the final borrow is 1; bout still reports 1.
REQ-026 SHALL, without SERIAL_SUB_SATURATE_EN, output the wrapped modulo-2^WIDTH difference; there SHALL be no other behavioural difference.

Structure
REQ-027 SHALL place the FSM state encoding (IDLE/SHIFT/DONE) and the default WIDTH constant in a shared package, sub_pkg.
REQ-028 SHALL instantiate exactly one combinational sub-module, full_subtractor (a, b, bin -> d, bout), as the per-bit datapath cell.

Verification
REQ-029 SHALL cover: WIDTH=3, A=5, B=3, bin=0, start -> done after 4 cycles, D=2, bout=0.
REQ-030 SHALL cover: A=2, B=5, bin=0 -> D=5, bout=1 without macro; D=0, bout=1 with SERIAL_SUB_SATURATE_EN.
REQ-031 SHALL cover: A=7, B=7, bin=1 -> D=7, bout=1; and A=0, B=0, bin=0 -> D=0, bout=0.
REQ-032 SHALL cover: start pulsed again 1 cycle after acceptance with different operands -> ignored; first result unchanged and exactly one done pulse.
REQ-033 SHALL cover: rst asserted in the 2nd SHIFT cycle -> no done pulse, ready=1, D=0; a following start with A=6, B=1 gives D=5.
REQ-034 SHALL cover: back-to-back starts issued on the first ready cycle after each done -> every result correct, done spacing exactly WIDTH+2 cycles.
